// File: rtl/dma_primitives.sv
`default_nettype none
// ============================================================================
// Module      : dma_primitives (file also holds register, counter, fifo)
// Description : Storage and counting primitives for the DMA controller
//               datapath. The top wrapper exposes one instance of each.
//               register - enable-loaded data register
//               counter  - up counter with qualified load and terminal count
//               fifo     - circular FIFO with partial-empty flag and a
//                          single-step rollback used for memory retries
// Ports (top) : clk, rst (async, active-high)
//               reg_en, reg_data_in, reg_data_out
//               cnt_en, cnt_load, cnt_data_in, cnt, end_cnt
//               fifo_enable, fifo_wr_rd, fifo_in, fifo_out,
//               fifo_old_add_flag, full, empty, empty_partial
// Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// register: data_out loads data_in when reg_en is high, otherwise holds.
// ----------------------------------------------------------------------------
module register #(
    parameter int REG_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 reg_en,
    input  logic [REG_DEPTH-1:0] data_in,
    output logic [REG_DEPTH-1:0] data_out
);

    logic [REG_DEPTH-1:0] r_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
        end else if (reg_en) begin
            r_data <= data_in;
        end
    end

    assign data_out = r_data;

endmodule

// ----------------------------------------------------------------------------
// counter: load has priority over increment; both need cnt_en.
// end_cnt flags the all-ones value combinationally.
// ----------------------------------------------------------------------------
module counter #(
    parameter int L = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cnt_en,
    input  logic         load,
    input  logic [L-1:0] data_in,
    output logic [L-1:0] cnt,
    output logic         end_cnt
);

    localparam logic [L-1:0] c_ONE = L'(1);

    logic [L-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (cnt_en) begin
            if (load) begin
                r_cnt <= data_in;
            end else begin
                r_cnt <= r_cnt + c_ONE;  // natural wrap from all-ones to 0
            end
        end
    end

    assign cnt     = r_cnt;
    assign end_cnt = &r_cnt;

endmodule

// ----------------------------------------------------------------------------
// fifo: single-direction-per-cycle circular buffer.
// A rising edge on fifo_old_add_flag undoes one step in the current
// direction: in write mode the last stored word is dropped, in read mode
// the last read word is made readable again. While the flag stays high all
// pointer/occupancy activity is frozen.
// ----------------------------------------------------------------------------
module fifo #(
    parameter int DATA       = 16,
    parameter int ADDR_SIZE  = 5,
    parameter int DIV_FACTOR = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fifo_enable,
    input  logic            fifo_wr_rd,
    input  logic [DATA-1:0] fifo_in,
    output logic [DATA-1:0] fifo_out,
    input  logic            fifo_old_add_flag,
    output logic            full,
    output logic            empty,
    output logic            empty_partial
);

    localparam int                   DEPTH     = 1 << ADDR_SIZE;
    localparam logic [ADDR_SIZE:0]   c_DEPTH   = DEPTH[ADDR_SIZE:0];
    localparam logic [ADDR_SIZE:0]   c_PARTIAL = c_DEPTH >> DIV_FACTOR;
    localparam logic [ADDR_SIZE-1:0] c_PTR_ONE = ADDR_SIZE'(1);
    localparam logic [ADDR_SIZE:0]   c_CNT_ONE = (ADDR_SIZE + 1)'(1);

    logic [DATA-1:0]      r_mem [DEPTH];
    logic [ADDR_SIZE-1:0] r_wr_ptr;
    logic [ADDR_SIZE-1:0] r_rd_ptr;
    logic [ADDR_SIZE:0]   r_count;
    logic [DATA-1:0]      r_out;
    logic                 r_flag_d;

    logic w_write;
    logic w_read;
    logic w_rb_edge;
    logic w_rb_wr;
    logic w_rb_rd;

    assign full          = (r_count == c_DEPTH);
    assign empty         = (r_count == '0);
    assign empty_partial = (r_count <= c_PARTIAL);

    // Normal traffic is suppressed for the whole time the flag is high.
    assign w_write   = fifo_enable &  fifo_wr_rd & ~full  & ~fifo_old_add_flag;
    assign w_read    = fifo_enable & ~fifo_wr_rd & ~empty & ~fifo_old_add_flag;

    // Rollback happens only on the first flagged cycle and only when the
    // undo keeps occupancy inside 0..DEPTH.
    assign w_rb_edge = fifo_old_add_flag & ~r_flag_d;
    assign w_rb_wr   = w_rb_edge &  fifo_wr_rd & ~empty;
    assign w_rb_rd   = w_rb_edge & ~fifo_wr_rd & ~full;

    // Storage array: no reset, contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_wr_ptr] <= fifo_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_out    <= '0;
            r_flag_d <= 1'b0;
        end else begin
            r_flag_d <= fifo_old_add_flag;
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
                r_count  <= r_count + c_CNT_ONE;
            end else if (w_read) begin
                r_out    <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
                r_count  <= r_count - c_CNT_ONE;
            end else if (w_rb_wr) begin
                r_wr_ptr <= r_wr_ptr - c_PTR_ONE;
                r_count  <= r_count - c_CNT_ONE;
            end else if (w_rb_rd) begin
                r_rd_ptr <= r_rd_ptr - c_PTR_ONE;
                r_count  <= r_count + c_CNT_ONE;
            end
        end
    end

    assign fifo_out = r_out;

endmodule

// ----------------------------------------------------------------------------
// dma_primitives: wrapper exposing one instance of each primitive.
// ----------------------------------------------------------------------------
module dma_primitives #(
    parameter int REG_DEPTH  = 16,
    parameter int L          = 15,
    parameter int DATA       = 16,
    parameter int ADDR_SIZE  = 5,
    parameter int DIV_FACTOR = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    // register
    input  logic                 reg_en,
    input  logic [REG_DEPTH-1:0] reg_data_in,
    output logic [REG_DEPTH-1:0] reg_data_out,
    // counter
    input  logic                 cnt_en,
    input  logic                 cnt_load,
    input  logic [L-1:0]         cnt_data_in,
    output logic [L-1:0]         cnt,
    output logic                 end_cnt,
    // fifo
    input  logic                 fifo_enable,
    input  logic                 fifo_wr_rd,
    input  logic [DATA-1:0]      fifo_in,
    output logic [DATA-1:0]      fifo_out,
    input  logic                 fifo_old_add_flag,
    output logic                 full,
    output logic                 empty,
    output logic                 empty_partial
);

    register #(
        .REG_DEPTH (REG_DEPTH)
    ) u_register (
        .clk      (clk),
        .rst      (rst),
        .reg_en   (reg_en),
        .data_in  (reg_data_in),
        .data_out (reg_data_out)
    );

    counter #(
        .L (L)
    ) u_counter (
        .clk     (clk),
        .rst     (rst),
        .cnt_en  (cnt_en),
        .load    (cnt_load),
        .data_in (cnt_data_in),
        .cnt     (cnt),
        .end_cnt (end_cnt)
    );

    fifo #(
        .DATA       (DATA),
        .ADDR_SIZE  (ADDR_SIZE),
        .DIV_FACTOR (DIV_FACTOR)
    ) u_fifo (
        .clk               (clk),
        .rst               (rst),
        .fifo_enable       (fifo_enable),
        .fifo_wr_rd        (fifo_wr_rd),
        .fifo_in           (fifo_in),
        .fifo_out          (fifo_out),
        .fifo_old_add_flag (fifo_old_add_flag),
        .full              (full),
        .empty             (empty),
        .empty_partial     (empty_partial)
    );

endmodule
`default_nettype wire

// File: tb/tb_dma_primitives.sv
`default_nettype none
// ============================================================================
// Module      : tb_dma_primitives
// Description : Directed self-checking bench for dma_primitives. A queue
//               model of FIFO contents feeds a scoreboard of expected read
//               data that is popped when fifo_out becomes valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dma_primitives;

    logic        clk = 1'b0;
    logic        rst;
    logic        reg_en;
    logic [15:0] reg_data_in;
    logic [15:0] reg_data_out;
    logic        cnt_en;
    logic        cnt_load;
    logic [14:0] cnt_data_in;
    logic [14:0] cnt;
    logic        end_cnt;
    logic        fifo_enable;
    logic        fifo_wr_rd;
    logic [15:0] fifo_in;
    logic [15:0] fifo_out;
    logic        fifo_old_add_flag;
    logic        full;
    logic        empty;
    logic        empty_partial;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] model [$];   // words currently held in the FIFO
    logic [15:0] sb    [$];   // expected fifo_out values, one per read
    logic [15:0] last_out = '0;

    always #5 clk = ~clk;

    dma_primitives dut (
        .clk               (clk),
        .rst               (rst),
        .reg_en            (reg_en),
        .reg_data_in       (reg_data_in),
        .reg_data_out      (reg_data_out),
        .cnt_en            (cnt_en),
        .cnt_load          (cnt_load),
        .cnt_data_in       (cnt_data_in),
        .cnt               (cnt),
        .end_cnt           (end_cnt),
        .fifo_enable       (fifo_enable),
        .fifo_wr_rd        (fifo_wr_rd),
        .fifo_in           (fifo_in),
        .fifo_out          (fifo_out),
        .fifo_old_add_flag (fifo_old_add_flag),
        .full              (full),
        .empty             (empty),
        .empty_partial     (empty_partial)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [15:0] v);
        fifo_enable       = 1'b1;
        fifo_wr_rd        = 1'b1;
        fifo_in           = v;
        fifo_old_add_flag = 1'b0;
        if (model.size() < 32) model.push_back(v);
        tick();
        fifo_enable = 1'b0;
        check("wr_full",  full,  model.size() == 32);
        check("wr_empty", empty, model.size() == 0);
    endtask

    task automatic do_read;
        logic [15:0] exp;
        fifo_enable       = 1'b1;
        fifo_wr_rd        = 1'b0;
        fifo_old_add_flag = 1'b0;
        if (model.size() > 0) last_out = model.pop_front();
        sb.push_back(last_out);
        tick();
        fifo_enable = 1'b0;
        exp = sb.pop_front();
        check("rd_data",          fifo_out,      exp);
        check("rd_empty",         empty,         model.size() == 0);
        check("rd_empty_partial", empty_partial, model.size() <= 4);
    endtask

    initial begin
        rst = 1'b1; reg_en = 0; reg_data_in = 0; cnt_en = 0; cnt_load = 0;
        cnt_data_in = 0; fifo_enable = 0; fifo_wr_rd = 0; fifo_in = 0;
        fifo_old_add_flag = 0;
        tick(); tick();
        rst = 1'b0;
        tick();

        // reset state
        check("rst_reg",   reg_data_out,  0);
        check("rst_cnt",   cnt,           0);
        check("rst_end",   end_cnt,       0);
        check("rst_out",   fifo_out,      0);
        check("rst_empty", empty,         1);
        check("rst_full",  full,          0);
        check("rst_part",  empty_partial, 1);

        // register
        reg_en = 1; reg_data_in = 16'hBEEF; tick();
        check("reg_load", reg_data_out, 16'hBEEF);
        reg_en = 0; reg_data_in = 16'h1234; tick();
        check("reg_hold", reg_data_out, 16'hBEEF);
        #2 rst = 1'b1;
        #1 check("reg_async_rst", reg_data_out, 0);
        rst = 1'b0;
        tick();

        // counter
        cnt_en = 1; repeat (3) tick();
        check("cnt_3", cnt, 3);
        cnt_en = 0; cnt_load = 1; cnt_data_in = 15'h10; tick();
        check("cnt_load_no_en", cnt, 3);
        cnt_en = 1; tick();
        check("cnt_load", cnt, 15'h10);
        cnt_data_in = 15'h7FFE; tick();
        check("cnt_7ffe", cnt, 15'h7FFE);
        check("cnt_end_0", end_cnt, 0);
        cnt_load = 0; tick();
        check("cnt_7fff", cnt, 15'h7FFF);
        check("cnt_end_1", end_cnt, 1);
        tick();
        check("cnt_wrap", cnt, 0);
        check("cnt_end_wrap", end_cnt, 0);
        cnt_en = 0;

        // fifo fill / drain
        for (int i = 1; i <= 32; i++) do_write(16'(i));
        do_write(16'h0099);                 // ignored: full
        for (int i = 0; i < 28; i++) do_read();
        for (int i = 0; i < 4; i++) do_read();
        do_read();                          // ignored: empty, fifo_out holds 32
        check("drain_hold", fifo_out, 32);

        // write rollback
        do_write(16'd7); do_write(16'd8); do_write(16'd9);
        fifo_enable = 0; fifo_wr_rd = 1; fifo_old_add_flag = 1;
        repeat (3) tick();
        if (model.size() > 0) void'(model.pop_back());
        fifo_old_add_flag = 0; tick();
        check("wrb_empty", empty, 0);
        do_read(); do_read();
        check("wrb_done_empty", empty, 1);

        // read rollback
        do_write(16'h000A); do_write(16'h000B);
        do_read();
        fifo_enable = 1; fifo_wr_rd = 0; fifo_old_add_flag = 1;
        tick(); tick();
        model.push_front(last_out);
        check("rrb_out_hold", fifo_out, 16'h000A);
        check("rrb_empty",    empty,    0);
        do_read(); do_read();

        // reset mid-operation
        for (int i = 0; i < 10; i++) do_write(16'(100 + i));
        #2 rst = 1'b1;
        #1;
        check("mid_rst_empty", empty,         1);
        check("mid_rst_out",   fifo_out,      0);
        check("mid_rst_full",  full,          0);
        check("mid_rst_part",  empty_partial, 1);
        model.delete();
        last_out = '0;
        rst = 1'b0;
        tick();
        do_write(16'h0055); do_write(16'h0066);
        do_read(); do_read();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dma_primitives.md
# dma_primitives

Storage and counting primitives for the DMA controller datapath: `register`, `counter` and `fifo`. The DMA control FSM uses them as follows:
- `register` latches the word count, the start address, the retry (old) address and the saved device/MSP counts.
- `counter` generates the address offset and the transferred-word count, with save/restore of the count.
- `fifo` buffers words between the device and the OpenMSP430 memory backbone. It supports a partial-drain threshold and single-step rollback for memory retries.

## Interface
Parameters:
- `register.REG_DEPTH`, 16: data width.
- `counter.L`, 15: count width.
- `fifo.DATA`, 16: word width.
- `fifo.ADDR_SIZE`, 5: log2 of depth (depth = 2^ADDR_SIZE = 32).
- `fifo.DIV_FACTOR`, 3: partial-empty threshold = depth >> DIV_FACTOR (4 by default).

Ports, all modules (one clock; reset is asynchronous and active-high):
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous active-high reset.

`register`:
- `reg_en` in 1: load enable.
- `data_in` in REG_DEPTH: load value.
- `data_out` out REG_DEPTH: stored value.

`counter`:
- `cnt_en` in 1: count/load enable.
- `load` in 1: load request; qualified by `cnt_en`.
- `data_in` in L: load value.
- `cnt` out L: current count.
- `end_cnt` out 1: terminal count.

`fifo`:
- `fifo_enable` in 1: operation enable.
- `fifo_wr_rd` in 1: direction, 1 = write, 0 = read.
- `fifo_in` in DATA: write data.
- `fifo_out` out DATA: read data (registered).
- `fifo_old_add_flag` in 1: retry/rollback request.
- `full` out 1: occupancy = depth.
- `empty` out 1: occupancy = 0.
- `empty_partial` out 1: occupancy <= depth >> DIV_FACTOR.

## Operation
`register`:
- `rst`: `data_out` = 0.
- Else at a clock edge with `reg_en` = 1: `data_out` <= `data_in`.
- Otherwise hold.

`counter`, priority order:
1. `rst`: `cnt` = 0.
2. `cnt_en` & `load`: `cnt` <= `data_in`.
3. `cnt_en`: `cnt` <= `cnt` + 1, modulo 2^L; all-ones wraps to 0.
4. `load` without `cnt_en`: no effect.

`end_cnt` is combinational, `cnt` == all-ones.

`fifo`:
- State: circular memory, `wr_ptr` and `rd_ptr` (ADDR_SIZE bits), occupancy counter (ADDR_SIZE+1 bits).
- Write (`fifo_enable` & `fifo_wr_rd` & !`full`): mem[`wr_ptr`] <= `fifo_in`, `wr_ptr`++, occupancy++.
- Read (`fifo_enable` & !`fifo_wr_rd` & !`empty`): `fifo_out` <= mem[`rd_ptr`], `rd_ptr`++, occupancy--.
- Write when full and read when empty are ignored; pointers, occupancy and `fifo_out` hold.
- Pointers wrap modulo depth.
- `full`, `empty` and `empty_partial` are combinational from occupancy.

Rollback:
- Triggers on the first cycle `fifo_old_add_flag` is 1 after being 0.
- In write direction: `wr_ptr`--, occupancy--, discarding the last stored word.
- In read direction: `rd_ptr`--, occupancy++, so the next read re-presents the unaccepted word.
- No rollback if the occupancy limit would be violated (occupancy 0 for write, occupancy = depth for read).
- While the flag stays high, pointers and occupancy hold regardless of `fifo_enable`.

Reset (`rst`): pointers = 0, occupancy = 0, `fifo_out` = 0, rollback edge-detect cleared. Memory contents are don't-care.

## Timing
- All state updates occur on the rising edge of `clk`. `rst` acts immediately and asynchronously, and overrides everything, including mid-operation.
- Reset values of outputs:
  - `data_out` = 0.
  - `cnt` = 0, `end_cnt` = 0 (for L > 0).
  - `fifo_out` = 0.
  - `empty` = 1, `full` = 0, `empty_partial` = 1.
- Latency:
  - `register` and `counter`: 1 cycle.
  - `fifo` write-to-`full`/`empty` update: 1 cycle.
  - `fifo` read data appears on `fifo_out` the cycle after the read edge.
- A write into an empty FIFO is readable on the next cycle. There are no simultaneous read and write; direction is a single bit.
- Flags track occupancy exactly at every edge, including rollback edges.

## Test plan
- register, REG_DEPTH = 16:
  - load 0xBEEF with `reg_en` = 1 -> `data_out` = 0xBEEF next edge.
  - `reg_en` = 0 and `data_in` = 0x1234 -> holds 0xBEEF.
  - async `rst` -> 0 immediately, without a clock edge.
- counter, L = 15:
  - `cnt_en` for 3 edges -> `cnt` = 3.
  - `load` = 1 with `cnt_en` = 0 and `data_in` = 0x10 -> stays 3.
  - `load` & `cnt_en` -> 0x10.
  - load 0x7FFE, count once -> `end_cnt` = 1 at 0x7FFF; next edge `cnt` = 0, `end_cnt` = 0.
- fifo fill/drain, depth 32:
  - write 1..32 -> `full` = 1 after the 32nd write; a 33rd write is ignored.
  - read 28 words -> outputs 1..28 in order; `empty_partial` rises when occupancy reaches 4.
  - read 4 more -> `empty` = 1; a further read leaves `fifo_out` = 32.
- fifo write rollback: write 7, 8, 9; pulse `fifo_old_add_flag` for 3 cycles in write mode -> occupancy 2; read returns 7, 8, then `empty`.
- fifo read rollback: write A, B; read -> A; raise flag in read mode with `fifo_enable` = 1 for 2 cycles -> single rollback; drop flag, read -> A again, then B.
- Reset mid-operation: assert `rst` with occupancy 10 -> `empty` = 1, `fifo_out` = 0 immediately; first write afterwards lands at address 0.
